i2c_reg_master: RTL and testbench
=================================

# i2c_reg_master

Register-access I2C initiator that drives the bus opposite the `i2cSlave` register block, replacing the Wishbone-programmed master plus bus-model pair for on-chip use. It executes one complete register write or register read per command, without software sequencing. Command inputs are single-cycle pulses; bus pins are open-drain enables for the top-level pad logic.

## Interface
- `QTR_DIV`, 30: `clk` cycles per quarter SCL bit; 50 MHz clock gives ≈417 kHz SCL. Legal range 2..255.
- `clk` input 1: sole clock, all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle command strobe; sampled only when `busy`=0.
- `rnw` input 1: 1 = register read, 0 = register write; captured with `start`.
- `devAddr` input 7: target 7-bit address, captured with `start`.
- `regAddr` input 8: register index, captured with `start`.
- `wrData` input 8: write payload, captured with `start`.
- `busy` output 1: high from the cycle after an accepted `start` until `done`.
- `done` output 1: one-cycle pulse at transaction end.
- `ackErr` output 1: valid with `done`; 1 = a NACK was received; held until the next accepted `start`.
- `rdData` output 8: read byte; updated only on successful read `done`, otherwise held.
- `sclIn`, `sdaIn` input 1: bus levels after the pads, already synchronised externally.
- `sclOe`, `sdaOe` output 1: 1 = pull the line low, 0 = release it.

## Operation
- Write sequence: START, `{devAddr,0}`, ACK, `regAddr`, ACK, `wrData`, ACK, STOP.
- Read sequence: START, `{devAddr,0}`, ACK, `regAddr`, ACK, repeated START, `{devAddr,1}`, ACK, 8 data bits, master NACK, STOP.
- All bytes are sent MSB first.
- States: IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_NACK, STOP, DONE.
- Transitions:
  - IDLE→START on `start`.
  - START→TX_BYTE.
  - TX_BYTE→RX_ACK after bit 0.
  - RX_ACK→next TX_BYTE, RESTART, RX_BYTE or STOP according to the byte index.
  - Any NACK (SDA sampled high in RX_ACK) sets `ackErr` and goes straight to STOP.
  - RESTART→TX_BYTE.
  - RX_BYTE→TX_NACK→STOP→DONE→IDLE.
- Byte index: 2-bit counter, 0..2 for write; read uses 0,1 before RESTART and 2 after.
- Bit counter: 3 bits, counting down 7..0.
- Receive shift register: 8 bits; `rdData` loads it in DONE when `ackErr`=0.
- `start` while `busy` is ignored and does not disturb the captured fields.
- No arbitration or multi-master support; SDA loopback is not checked while transmitting.

## Timing
- Every bit is 4 phases of `QTR_DIV` cycles each:
  - ph0: SCL low; drive the new SDA value at phase start.
  - ph1: SCL low.
  - ph2: SCL released.
  - ph3: SCL high.
- SDA is sampled on the last cycle of ph2.
- Clock stretching: the ph2 counter does not advance until `sclIn`=1.
- START (and RESTART): 4 phases.
  - SDA released, SCL released, SDA pulled low, SCL pulled low.
  - The START condition is the SDA fall while SCL is high.
- STOP: 4 phases.
  - SDA low, SCL released, then SDA released while SCL is high, then an idle phase.
- Latency from the accepted `start` to `done` with no stretching:
  - write: 116·`QTR_DIV`+2 cycles;
  - read: 156·`QTR_DIV`+2 cycles.
  - NACK on the first byte: 44·`QTR_DIV`+2 cycles.
- `busy` rises the cycle after `start`. `done` pulses for one cycle and `busy` falls in that same cycle.
- Reset values: `sclOe`=0, `sdaOe`=0, `busy`=0, `done`=0, `ackErr`=0, `rdData`=8'h00, state IDLE. Lines are released asynchronously on `rst` assertion, including mid-byte; no STOP is generated.

## Structure
- Package `i2c_reg_master_pkg` holds:
  - the state enum;
  - phase encoding (PH0..PH3);
  - R/W bit constants (`I2C_WR`=0, `I2C_RD`=1);
  - byte-index constants.
- Sub-module `i2c_bit_timer` contains the `QTR_DIV` divider and 2-bit phase counter.
  - Input `run`, `sclIn` (for the stretch hold).
  - Output `phase` and one-cycle `phaseEnd`/`bitEnd` strobes.
- The top level holds the FSM, shift registers and counters.

## Test plan
- Write test: write `devAddr`=7'h3c, `regAddr`=0, `wrData`=8'hA5 → `i2cSlave` `myReg0`=8'hA5, `ackErr`=0, `done` at 116·`QTR_DIV`+2 cycles.
- Read test: read `regAddr`=4 with slave `myReg4`=8'h12 → `rdData`=8'h12, `ackErr`=0, bus checker sees exactly one repeated START and a final NACK.
- Wrong address: `devAddr`=7'h20 → `ackErr`=1 after the first byte, STOP generated, slave registers unchanged, `rdData` unchanged.
- Clock stretch: bench holds SCL low for 100 extra cycles on one bit → no bit lost, data correct, latency +100 cycles.
- Busy and reset: `start` pulsed mid-transaction → ignored. Then `rst` asserted during the `regAddr` byte → `sclOe`/`sdaOe`/`busy` all 0 immediately. After release, a fresh write to register 1 succeeds.

Source files
------------

// File: rtl/i2c_reg_master_pkg.sv
// Shared constants for the register-access I2C initiator: FSM states, bit phases,
// R/W bit values and byte-slot indices.
package i2c_reg_master_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned PHASE_W = 2;
    localparam int unsigned BYTE_W  = 2;

    localparam logic [STATE_W-1:0] ST_IDLE    = 4'd0;
    localparam logic [STATE_W-1:0] ST_START   = 4'd1;
    localparam logic [STATE_W-1:0] ST_TX_BYTE = 4'd2;
    localparam logic [STATE_W-1:0] ST_RX_ACK  = 4'd3;
    localparam logic [STATE_W-1:0] ST_RESTART = 4'd4;
    localparam logic [STATE_W-1:0] ST_RX_BYTE = 4'd5;
    localparam logic [STATE_W-1:0] ST_TX_NACK = 4'd6;
    localparam logic [STATE_W-1:0] ST_STOP    = 4'd7;
    localparam logic [STATE_W-1:0] ST_DONE    = 4'd8;

    localparam logic [PHASE_W-1:0] PH0 = 2'd0;
    localparam logic [PHASE_W-1:0] PH1 = 2'd1;
    localparam logic [PHASE_W-1:0] PH2 = 2'd2;
    localparam logic [PHASE_W-1:0] PH3 = 2'd3;

    localparam logic I2C_WR = 1'b0;
    localparam logic I2C_RD = 1'b1;

    localparam logic [BYTE_W-1:0] BYTE_DEV  = 2'd0;
    localparam logic [BYTE_W-1:0] BYTE_REG  = 2'd1;
    localparam logic [BYTE_W-1:0] BYTE_DATA = 2'd2;

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-bit divider and phase counter; each bit is four phases of QTR_DIV cycles.
module i2c_bit_timer
    import i2c_reg_master_pkg::*;
#(
    parameter int unsigned QTR_DIV = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               sclIn,
    output logic [PHASE_W-1:0] phase,
    output logic               phaseEnd_c,
    output logic               bitEnd_c
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               last_c;
    logic               hold_c;

    // ph2 waits at its final count until SCL is seen high, absorbing target stretching
    assign last_c     = (cnt_q == CNT_W'(QTR_DIV - 1));
    assign hold_c     = (phase_q == PH2) && !sclIn;
    assign phaseEnd_c = run && last_c && !hold_c;
    assign bitEnd_c   = phaseEnd_c && (phase_q == PH3);
    assign phase      = phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!run) begin
            cnt_d   = '0;
            phase_d = PH0;
        end else if (phaseEnd_c) begin
            cnt_d   = '0;
            phase_d = phase_q + PHASE_W'(1);
        end else if (!last_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            phase_q <= PH0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/i2c_reg_master.sv
// I2C initiator that performs one complete register write or register read per
// start strobe; SCL/SDA are open-drain pull-down enables.
module i2c_reg_master
    import i2c_reg_master_pkg::*;
#(
    parameter int unsigned QTR_DIV = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rnw,
    input  logic [6:0] devAddr,
    input  logic [7:0] regAddr,
    input  logic [7:0] wrData,
    output logic       busy,
    output logic       done,
    output logic       ackErr,
    output logic [7:0] rdData,
    input  logic       sclIn,
    input  logic       sdaIn,
    output logic       sclOe,
    output logic       sdaOe
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [2:0]         bit_q, bit_d;
    logic [BYTE_W-1:0]  byte_q, byte_d;
    logic               rnw_q, rnw_d;
    logic [6:0]         dev_q, dev_d;
    logic [7:0]         reg_q, reg_d;
    logic [7:0]         wdat_q, wdat_d;
    logic [7:0]         rx_q, rx_d;
    logic               samp_q, samp_d;
    logic               ack_err_q, ack_err_d;
    logic [7:0]         rd_q, rd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               scl_oe_q, scl_oe_d;
    logic               sda_oe_q, sda_oe_d;

    logic [PHASE_W-1:0] phase;
    logic               phase_end_c;
    logic               bit_end_c;
    logic               run_c;
    logic [7:0]         tx_byte_c;
    logic               tx_bit_c;

    assign run_c = (state_q != ST_IDLE) && (state_q != ST_DONE);

    i2c_bit_timer #(.QTR_DIV(QTR_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .run        (run_c),
        .sclIn      (sclIn),
        .phase      (phase),
        .phaseEnd_c (phase_end_c),
        .bitEnd_c   (bit_end_c)
    );

    // byte slot 2 is the data byte on a write and the read-address byte after RESTART
    always_comb begin
        case (byte_q)
            BYTE_DEV: tx_byte_c = {dev_q, I2C_WR};
            BYTE_REG: tx_byte_c = reg_q;
            default:  tx_byte_c = (rnw_q == I2C_RD) ? {dev_q, I2C_RD} : wdat_q;
        endcase
    end
    assign tx_bit_c = tx_byte_c[bit_q];

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        rnw_d     = rnw_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        wdat_d    = wdat_q;
        rx_d      = rx_q;
        samp_d    = samp_q;
        ack_err_d = ack_err_q;
        rd_d      = rd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        scl_oe_d  = 1'b0;
        sda_oe_d  = 1'b0;

        // line drive for the current state and phase
        case (state_q)
            ST_START, ST_RESTART: begin
                sda_oe_d = phase[1];
                scl_oe_d = (phase == PH3) || ((phase == PH0) && (state_q == ST_RESTART));
            end
            ST_TX_BYTE: begin
                sda_oe_d = !tx_bit_c;
                scl_oe_d = !phase[1];
            end
            ST_RX_ACK, ST_RX_BYTE, ST_TX_NACK: scl_oe_d = !phase[1];
            ST_STOP: begin
                sda_oe_d = !phase[1];
                scl_oe_d = (phase == PH0);
            end
            default: ;
        endcase

        if (phase_end_c && (phase == PH2)) begin
            samp_d = sdaIn;
            if (state_q == ST_RX_BYTE) rx_d = {rx_q[6:0], sdaIn};
        end

        case (state_q)
            ST_IDLE: if (start) begin
                state_d   = ST_START;
                rnw_d     = rnw;
                dev_d     = devAddr;
                reg_d     = regAddr;
                wdat_d    = wrData;
                byte_d    = BYTE_DEV;
                bit_d     = 3'd7;
                ack_err_d = 1'b0;
                busy_d    = 1'b1;
            end
            ST_START, ST_RESTART: if (bit_end_c) begin
                state_d = ST_TX_BYTE;
                bit_d   = 3'd7;
            end
            ST_TX_BYTE: if (bit_end_c) begin
                if (bit_q == 3'd0) state_d = ST_RX_ACK;
                else               bit_d   = bit_q - 3'd1;
            end
            ST_RX_ACK: if (bit_end_c) begin
                bit_d = 3'd7;
                if (samp_q) begin
                    ack_err_d = 1'b1;
                    state_d   = ST_STOP;
                end else begin
                    case (byte_q)
                        BYTE_DEV: begin
                            byte_d  = BYTE_REG;
                            state_d = ST_TX_BYTE;
                        end
                        BYTE_REG: begin
                            byte_d  = BYTE_DATA;
                            state_d = (rnw_q == I2C_RD) ? ST_RESTART : ST_TX_BYTE;
                        end
                        default: state_d = (rnw_q == I2C_RD) ? ST_RX_BYTE : ST_STOP;
                    endcase
                end
            end
            ST_RX_BYTE: if (bit_end_c) begin
                if (bit_q == 3'd0) state_d = ST_TX_NACK;
                else               bit_d   = bit_q - 3'd1;
            end
            ST_TX_NACK: if (bit_end_c) state_d = ST_STOP;
            ST_STOP:    if (bit_end_c) state_d = ST_DONE;
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if ((rnw_q == I2C_RD) && !ack_err_q) rd_d = rx_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            bit_q     <= 3'd7;
            byte_q    <= BYTE_DEV;
            rnw_q     <= I2C_WR;
            dev_q     <= '0;
            reg_q     <= '0;
            wdat_q    <= '0;
            rx_q      <= '0;
            samp_q    <= 1'b0;
            ack_err_q <= 1'b0;
            rd_q      <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            rnw_q     <= rnw_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            wdat_q    <= wdat_d;
            rx_q      <= rx_d;
            samp_q    <= samp_d;
            ack_err_q <= ack_err_d;
            rd_q      <= rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            scl_oe_q  <= scl_oe_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign ackErr = ack_err_q;
    assign rdData = rd_q;
    assign sclOe  = scl_oe_q;
    assign sdaOe  = sda_oe_q;

endmodule

// File: tb/tb_i2c_reg_master.sv
// Bench for i2c_reg_master: behavioural register target on the bus, transaction-level
// reference model, randomized write/read traffic, stretching and reset cases.
`timescale 1ns/1ps
module tb_i2c_reg_master;

    localparam int unsigned QTR       = 4;
    localparam logic [6:0]  SLV_ADDR  = 7'h3c;
    localparam logic [6:0]  BAD_ADDR  = 7'h20;
    localparam int          LAT_LIMIT = 200 * QTR + 200;
    localparam int          STRETCH   = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       rnw = 1'b0;
    logic [6:0] devAddr = '0;
    logic [7:0] regAddr = '0;
    logic [7:0] wrData = '0;
    logic       busy, done, ackErr;
    logic [7:0] rdData;
    logic       sclIn, sdaIn, sclOe, sdaOe;
    logic       slv_sda_oe = 1'b0;
    logic       tb_scl_hold = 1'b0;

    assign sclIn = !(sclOe || tb_scl_hold);
    assign sdaIn = !(sdaOe || slv_sda_oe);

    i2c_reg_master #(.QTR_DIV(QTR)) dut (
        .clk(clk), .rst(rst), .start(start), .rnw(rnw), .devAddr(devAddr),
        .regAddr(regAddr), .wrData(wrData), .busy(busy), .done(done), .ackErr(ackErr),
        .rdData(rdData), .sclIn(sclIn), .sdaIn(sdaIn), .sclOe(sclOe), .sdaOe(sdaOe)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // target register file (written over the bus) and the model's copy
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] ref_rd = 8'h00;

    int         n_start = 0, n_stop = 0, oe_falls = 0, stretch_at = 0, hold_cnt = 0;
    int         bitn = 0, byte_num = 0;
    bit         in_xfer = 0, tx_mode = 0, addressed = 0, rd_dir = 0, m_ack_last = 1;
    logic [7:0] sh = '0, txb = '0, ptr = '0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_scl_oe = 1'b0;
    logic       scl, sda;

    // behavioural target plus bus-event counters, evaluated mid-cycle
    initial begin : target
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_xfer = 0; tx_mode = 0; slv_sda_oe = 1'b0; tb_scl_hold = 1'b0; hold_cnt = 0;
                prev_scl = 1'b1; prev_sda = 1'b1; prev_scl_oe = 1'b0;
                continue;
            end
            if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) tb_scl_hold = 1'b0;
            end else if (prev_scl_oe && !sclOe) begin
                oe_falls++;
                if (oe_falls == stretch_at) begin
                    // keep SCL low until STRETCH cycles past the normal end of ph2
                    hold_cnt    = int'(QTR) - 2 + STRETCH;
                    tb_scl_hold = 1'b1;
                end
            end
            prev_scl_oe = sclOe;
            scl = !(sclOe || tb_scl_hold);
            sda = !(sdaOe || slv_sda_oe);
            if (prev_scl && scl && prev_sda && !sda) begin
                n_start++; in_xfer = 1; bitn = -1; byte_num = 0; tx_mode = 0;
                m_ack_last = 1; slv_sda_oe = 1'b0;
            end else if (prev_scl && scl && !prev_sda && sda) begin
                n_stop++; in_xfer = 0; tx_mode = 0; slv_sda_oe = 1'b0;
            end else if (in_xfer && !prev_scl && scl) begin
                if (bitn >= 0 && bitn < 8) begin
                    if (!tx_mode) sh = {sh[6:0], sda};
                end else if (bitn == 8 && tx_mode) begin
                    m_ack_last = !sda;
                end
            end else if (in_xfer && prev_scl && !scl) begin
                if (bitn < 0) begin
                    bitn = 0;
                end else if (bitn < 7) begin
                    bitn++;
                    if (tx_mode) slv_sda_oe = !txb[7 - bitn];
                end else if (bitn == 7) begin
                    bitn = 8;
                    if (tx_mode) begin
                        slv_sda_oe = 1'b0;
                    end else begin
                        if (byte_num == 0) begin
                            addressed = (sh[7:1] == SLV_ADDR);
                            rd_dir    = sh[0];
                        end else if (byte_num == 1 && !rd_dir) begin
                            ptr = sh;
                        end else if (!rd_dir) begin
                            mem[ptr] = sh;
                            ptr++;
                        end
                        slv_sda_oe = addressed;
                        if (!addressed) in_xfer = 0;
                    end
                end else begin
                    bitn = 0;
                    byte_num++;
                    slv_sda_oe = 1'b0;
                    if (rd_dir && (byte_num == 1 || (tx_mode && m_ack_last))) begin
                        tx_mode    = 1;
                        txb        = mem[ptr];
                        ptr++;
                        slv_sda_oe = !txb[7];
                    end else begin
                        tx_mode = 0;
                    end
                end
            end
            prev_scl = scl;
            prev_sda = sda;
        end
    end

    // drive one command from a negedge and wait for done; fields are scrambled while busy
    task automatic do_xfer(input logic r, input logic [6:0] dev, input logic [7:0] ra,
                           input logic [7:0] wd, input int stretch, input int pulse_at,
                           output int lat);
        n_start = 0; n_stop = 0; oe_falls = 0; stretch_at = stretch;
        start = 1'b1; rnw = r; devAddr = dev; regAddr = ra; wrData = wd;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start   = 1'b0;
            rnw     = ~r;
            devAddr = 7'($urandom);
            regAddr = 8'($urandom);
            wrData  = 8'($urandom);
            if (lat == pulse_at) start = 1'b1;
            if (lat == 1) check("busy_rise", 32'(busy), 32'd1);
        end while (!done && lat < LAT_LIMIT);
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        check("busy_fall", 32'(busy), 32'd0);
    endtask

    task automatic run_check(input string tag, input logic r, input logic [6:0] dev,
                             input logic [7:0] ra, input logic [7:0] wd,
                             input int stretch, input int pulse_at);
        int  lat, exp_lat, diffs;
        bit  nack;
        nack    = (dev != SLV_ADDR);
        exp_lat = (nack ? 44 : (r ? 156 : 116)) * int'(QTR) + 2 + ((stretch != 0) ? STRETCH : 0);
        if (!nack && !r) ref_mem[ra] = wd;
        if (!nack && r)  ref_rd = ref_mem[ra];
        do_xfer(r, dev, ra, wd, stretch, pulse_at, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_ackErr"}, 32'(ackErr), 32'(nack));
        check({tag, "_rdData"}, 32'(rdData), 32'(ref_rd));
        check({tag, "_stops"}, 32'(n_stop), 32'd1);
        check({tag, "_starts"}, 32'(n_start), (r && !nack) ? 32'd2 : 32'd1);
        if (r && !nack) check({tag, "_mnack"}, 32'(m_ack_last), 32'd0);
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check({tag, "_mem"}, 32'(diffs), 32'd0);
    endtask

    initial begin : stim
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[4] = 8'h12;
        ref_mem[4] = 8'h12;

        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sclOe", 32'(sclOe), 32'd0);
        check("rst_sdaOe", 32'(sdaOe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ackErr", 32'(ackErr), 32'd0);
        check("rst_rdData", 32'(rdData), 32'd0);

        run_check("wr_a5", 1'b0, SLV_ADDR, 8'h00, 8'hA5, 0, 0);
        run_check("rd_r4", 1'b1, SLV_ADDR, 8'h04, 8'h00, 0, 0);
        run_check("bad_addr", 1'b1, BAD_ADDR, 8'h04, 8'h00, 0, 0);
        run_check("stretch_wr", 1'b0, SLV_ADDR, 8'h03, 8'h5C, 5, 0);
        run_check("stretch_rd", 1'b1, SLV_ADDR, 8'h03, 8'h00, 0, 0);
        run_check("busy_ign", 1'b0, SLV_ADDR, 8'h02, 8'h3E, 0, 200);
        run_check("busy_ign_rd", 1'b1, SLV_ADDR, 8'h02, 8'h00, 0, 300);

        for (int k = 0; k < 16; k++) begin
            logic       r;
            logic [6:0] dev;
            r   = 1'($urandom_range(0, 1));
            dev = ($urandom_range(0, 5) == 0) ? BAD_ADDR : SLV_ADDR;
            run_check("rand", r, dev, 8'($urandom_range(0, 15)), 8'($urandom), 0, 0);
        end

        // abort a write partway through the register-address byte
        n_start = 0; n_stop = 0; oe_falls = 0; stretch_at = 0;
        start = 1'b1; rnw = 1'b0; devAddr = SLV_ADDR; regAddr = 8'h01; wrData = 8'hC3;
        @(negedge clk);
        start = 1'b0;
        repeat (49 * QTR + 1) @(negedge clk);
        check("pre_rst_sclOe", 32'(sclOe), 32'd1);
        rst = 1'b0;
        #1;
        check("arst_sclOe", 32'(sclOe), 32'd0);
        check("arst_sdaOe", 32'(sdaOe), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rdData", 32'(rdData), 32'd0);
        ref_rd = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2 * QTR) @(negedge clk);
        run_check("post_rst_wr", 1'b0, SLV_ADDR, 8'h01, 8'h96, 0, 0);
        run_check("post_rst_rd", 1'b1, SLV_ADDR, 8'h01, 8'h00, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
